// File: rtl/viterbi_pkg.sv
// Shared types and trellis helpers for the hard-decision Viterbi block decoder.
// Widths derive from (K, r, lenout) through the calc_* functions.
package viterbi_pkg;

    typedef enum logic [1:0] {ACS, TRACE, DONE} fsm_e;

    function automatic int calc_ns(input int k);
        return 1 << (k - 1);
    endfunction

    // Sentinel r*lenout+1 plus up to r*lenout of branch cost must fit without wrap
    function automatic int calc_w(input int rr, input int n);
        return $clog2(2 * rr * n + 2);
    endfunction

    localparam int R_DEF      = 2;
    localparam int K_DEF      = 3;
    localparam int LENOUT_DEF = 5;
    localparam int NS_DEF     = calc_ns(K_DEF);
    localparam int W_DEF      = calc_w(R_DEF, LENOUT_DEF);

    function automatic int next_state(input int s, input int b, input int ns);
        return ((s << 1) | b) % ns;
    endfunction

    function automatic int pred0(input int s, input int ns);
        return (s >> 1) + 0 * ns;
    endfunction

    function automatic int pred1(input int s, input int ns);
        return (s >> 1) + ns / 2;
    endfunction

    function automatic int hamming(input logic [31:0] x);
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) c += int'(x[i]);
        return c;
    endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state; ties resolve to the p0 branch.
module viterbi_acs #(
    parameter int W = 5
) (
    input  logic [W-1:0] pm0,
    input  logic [W-1:0] pm1,
    input  logic [W-1:0] bm0,
    input  logic [W-1:0] bm1,
    output logic [W-1:0] pm_new,
    output logic         sel
);

    logic [W-1:0] c0, c1;

    assign c0     = pm0 + bm0;
    assign c1     = pm1 + bm1;
    assign sel    = (c1 < c0);
    assign pm_new = sel ? c1 : c0;

endmodule

// File: rtl/viterbi_decoder.sv
// One-shot block Viterbi decoder: N ACS steps, N traceback steps, then hold
// the decoded block with vfinish until the next reset.
module viterbi_decoder
    import viterbi_pkg::*;
#(
    parameter int r      = 2,
    parameter int K      = 3,
    parameter int lenin  = 10,
    parameter int lenout = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [lenin-1:0]              vcodein,
    input  logic [calc_ns(K)*2*r-1:0]     vstate_out,
    output logic [lenout-1:0]             vcodeout,
    output logic                          vfinish
);

    localparam int NS = calc_ns(K);
    localparam int W  = calc_w(r, lenout);
    localparam int SW = K - 1;
    localparam int CW = (lenout > 1) ? $clog2(lenout) : 1;

    fsm_e                       st, st_nxt;
    logic [CW-1:0]              cnt, cnt_nxt;
    logic                       acs_en, tb_en, fin_set;
    logic [NS-1:0][W-1:0]       pm, pm_nxt;
    logic [NS-1:0]              sel;
    logic [lenout-1:0][NS-1:0]  surv;
    logic [r-1:0]               sym;
    logic [SW-1:0]              best, cur, tb_cur, pred_st;
    logic [W-1:0]               bpm;
    logic                       sbit;
    logic [lenout-1:0]          onehot;

    assign sym = r'(vcodein >> (lenin - r - r * int'(cnt)));

    for (genvar s = 0; s < NS; s++) begin : g_st
        localparam int P0 = pred0(s, NS);
        localparam int P1 = pred1(s, NS);
        localparam int B  = s % 2;
        logic [r-1:0] e0, e1;
        logic [W-1:0] bm0, bm1;

        assign e0  = vstate_out[(2*P0+B)*r +: r];
        assign e1  = vstate_out[(2*P1+B)*r +: r];
        assign bm0 = W'(hamming(32'(sym ^ e0)));
        assign bm1 = W'(hamming(32'(sym ^ e1)));

        viterbi_acs #(.W(W)) u_acs (
            .pm0    (pm[P0]),
            .pm1    (pm[P1]),
            .bm0    (bm0),
            .bm1    (bm1),
            .pm_new (pm_nxt[s]),
            .sel    (sel[s])
        );
    end

    // Minimum final metric; strict compare keeps the lowest index on ties
    always_comb begin
        best = '0;
        bpm  = pm[0];
        for (int i = 1; i < NS; i++) begin
            if (pm[i] < bpm) begin
                bpm  = pm[i];
                best = SW'(i);
            end
        end
    end

    assign tb_cur  = (cnt == CW'(lenout - 1)) ? best : cur;
    assign sbit    = surv[cnt][tb_cur];
    assign pred_st = SW'(sbit ? pred1(int'(tb_cur), NS) : pred0(int'(tb_cur), NS));
    assign onehot  = lenout'(1) << (lenout - 1 - int'(cnt));

    always_comb begin
        st_nxt  = st;
        cnt_nxt = cnt;
        acs_en  = 1'b0;
        tb_en   = 1'b0;
        fin_set = 1'b0;
        case (st)
            ACS: begin
                acs_en = 1'b1;
                if (cnt == CW'(lenout - 1)) st_nxt  = TRACE;
                else                        cnt_nxt = cnt + 1'b1;
            end
            TRACE: begin
                tb_en = 1'b1;
                if (cnt == '0) begin
                    st_nxt  = DONE;
                    fin_set = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= ACS;
            cnt      <= '0;
            cur      <= '0;
            vcodeout <= '0;
            vfinish  <= 1'b0;
            for (int i = 0; i < NS; i++)
                pm[i] <= (i == 0) ? '0 : W'(r * lenout + 1);
        end else begin
            st  <= st_nxt;
            cnt <= cnt_nxt;
            if (acs_en) pm <= pm_nxt;
            if (tb_en) begin
                vcodeout <= (vcodeout & ~onehot) | (tb_cur[0] ? onehot : '0);
                cur      <= pred_st;
            end
            if (fin_set) vfinish <= 1'b1;
        end
    end

    // Survivor bits need no reset; they are always written before traceback reads them
    always_ff @(posedge clk) begin
        if (acs_en) surv[cnt] <= sel;
    end

endmodule

// File: tb/tb_viterbi_decoder.sv
// Directed bench for viterbi_decoder with the (7,5) K=3 rate-1/2 code table.
module tb_viterbi_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] vcodein = '0;
    logic [15:0] vstate_out = '0;
    logic [4:0] vcodeout;
    logic       vfinish;

    int nchk = 0;
    int nfail = 0;

    viterbi_decoder #(.r(2), .K(3), .lenin(10), .lenout(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .vcodein    (vcodein),
        .vstate_out (vstate_out),
        .vcodeout   (vcodeout),
        .vfinish    (vfinish)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [9:0]  code;
        logic [15:0] tbl;
        logic [4:0]  exp_out;
        int          exp_pm;
    } vec_t;

    vec_t vecs[3];

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int min_pm();
        int m;
        m = int'(dut.pm[0]);
        for (int i = 1; i < 4; i++)
            if (int'(dut.pm[i]) < m) m = int'(dut.pm[i]);
        return m;
    endfunction

    // Release reset at a negedge, then step decode edges 1..n sampling #1 after each
    task automatic run_edges(input string name, input int n, input logic [4:0] exp_out, input int exp_pm);
        for (int e = 1; e <= n; e++) begin
            @(posedge clk);
            #1;
            if (e < 10) check({name, " vfinish low"}, int'(vfinish), 0);
            else begin
                check({name, " vfinish edge10"}, int'(vfinish), 1);
                check({name, " vcodeout"}, int'(vcodeout), int'(exp_out));
                check({name, " final pm"}, min_pm(), exp_pm);
            end
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check({name, " rst vcodeout"}, int'(vcodeout), 0);
        check({name, " rst vfinish"}, int'(vfinish), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"err1",  10'b1111010001, 16'b1001001101101100, 5'b11011, 1};
        vecs[1] = '{"clean", 10'b1110000101, 16'b1001001101101100, 5'b10110, 0};
        vecs[2] = '{"zero",  10'b0000000000, 16'b1001001101101100, 5'b00000, 0};

        for (int v = 0; v < 3; v++) begin
            @(negedge clk);
            vcodein    = vecs[v].code;
            vstate_out = vecs[v].tbl;
            do_reset(vecs[v].name);
            run_edges(vecs[v].name, 10, vecs[v].exp_out, vecs[v].exp_pm);
        end

        // Reset mid-traceback: outputs clear asynchronously, decode restarts cleanly
        @(negedge clk);
        vcodein = vecs[0].code;
        do_reset("midtb");
        for (int e = 1; e <= 7; e++) @(posedge clk);
        #1;
        check("midtb partial", int'(vcodeout), 3);
        check("midtb vfinish pre", int'(vfinish), 0);
        rst = 1'b1;
        #1;
        check("midtb async vcodeout", int'(vcodeout), 0);
        check("midtb async vfinish", int'(vfinish), 0);
        @(posedge clk);
        #1;
        check("midtb held vcodeout", int'(vcodeout), 0);
        @(negedge clk);
        rst = 1'b0;
        run_edges("midtb rerun", 10, 5'b11011, 1);

        // DONE ignores input changes
        @(negedge clk);
        vcodein = 10'b0000000000;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            check("hold vcodeout", int'(vcodeout), 27);
            check("hold vfinish", int'(vfinish), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
